line_fifo_sequencer: RTL and testbench
======================================

Name: line_fifo_sequencer

Overview:
- Owns the single shared 16-bit line FIFO and the board-level phase machine: RECEIVE → SOLVE → TRANSMIT → FLUSH.
- Muxes FIFO writes between parser and solver, gates solver reads, and tracks FIFO occupancy.
- Flags overflow and writes in the wrong phase, and aborts a solve that exceeds a cycle budget.
- Sits in top_level between parser/solver/assembler and the FIFO IP; replaces the inline state register and write mux.

Parameters:
- LINE_W, 16, width of one FIFO entry (option line).
- FIFO_DEPTH, 1024, FIFO IP depth; the occupancy counter is $clog2(FIFO_DEPTH+1) bits wide.
- SOLVE_BUDGET, 50_000_000, maximum cycles allowed in SOLVE before the ERROR state.

Ports:
- clk  in  1  system clock (50 MHz domain).
- rst  in  1  synchronous active-high reset.
- parse_write  in  1  parser requests a write.
- parse_line  in  LINE_W  parser write data.
- parsed  in  1  one-cycle pulse: board fully parsed.
- solve_write  in  1  solver requests a write-back.
- solve_line  in  LINE_W  solver write data.
- solve_next  in  1  solver requests a FIFO pop.
- solved  in  1  one-cycle pulse: board solved.
- assembled  in  1  one-cycle pulse: transmit finished.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- fifo_din  out  LINE_W  FIFO write data.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_rd_en  out  1  FIFO read enable.
- phase  out  3  current state encoding.
- solve_start  out  1  one-cycle pulse on entering SOLVE.
- assemble_start  out  1  one-cycle pulse on entering TRANSMIT.
- occupancy  out  $clog2(FIFO_DEPTH+1)  entries currently held.
- overflow  out  1  sticky: a write was attempted while full.
- bad_write  out  1  sticky: a write request arrived in a phase that does not accept it.
- error  out  1  high while in ERROR.

Behaviour:
- State encodings: RECEIVE=0, SOLVE=1, TRANSMIT=2, FLUSH=3, ERROR=4.
- Reset values: phase=RECEIVE; occupancy=0; overflow, bad_write, solve_start, assemble_start and the watchdog counter all 0.
- Write mux (combinational):
  - RECEIVE: fifo_din=parse_line; fifo_wr_en=parse_write & ~fifo_full.
  - SOLVE: fifo_din=solve_line; fifo_wr_en=solve_write & ~fifo_full.
  - All other states: fifo_wr_en=0 and fifo_din=0.
- Read gating (combinational):
  - SOLVE: fifo_rd_en=solve_next & ~fifo_empty.
  - FLUSH: fifo_rd_en=~fifo_empty.
  - All other states: fifo_rd_en=0.
- Occupancy updates on the next edge: +1 on write only, −1 on read only, unchanged when both occur or neither occurs. It saturates at 0 and at FIFO_DEPTH.
- overflow sets when the active writer requests while fifo_full.
- bad_write sets on parse_write outside RECEIVE, or solve_write outside SOLVE. The request is dropped.
- Both sticky flags clear only on rst.
- Transitions, all registered:
  - RECEIVE→SOLVE on parsed. solve_start=1 in the first SOLVE cycle.
  - SOLVE→TRANSMIT on solved. assemble_start=1 in the first TRANSMIT cycle.
  - TRANSMIT→FLUSH on assembled.
  - FLUSH→RECEIVE on the cycle fifo_empty=1 is sampled. If FLUSH is entered while already empty, it lasts exactly 1 cycle.
  - SOLVE→ERROR when the watchdog reaches SOLVE_BUDGET−1 without solved.
  - ERROR→FLUSH on parsed, which starts recovery by draining stale lines; the new board's parse writes are refused during FLUSH and flagged in bad_write. Otherwise ERROR holds until rst.
- Simultaneous events:
  - solved and watchdog expiry in the same cycle: solved wins.
  - parsed arriving in any state other than RECEIVE or ERROR is ignored.
- Watchdog: zeroed on SOLVE entry, incremented every SOLVE cycle.
- Reset mid-operation: all state returns to reset values on the next edge. The FIFO IP's srst is driven from the same rst, so occupancy 0 stays consistent with the FIFO contents.

Optional Feature:
- Macro: LINE_FIFO_SEQ_STATS_EN.
- When defined:
  - Adds output solve_cycles [31:0], latched at SOLVE exit (solved or ERROR) with the watchdog value.
  - Adds output peak_occupancy, the maximum occupancy since the last RECEIVE entry.
  - Both reset to 0.
- When undefined: neither port nor its logic exists.

Decomposition:
- Package nono_pkg:
  - phase_t enum (RECEIVE..ERROR).
  - LINE_W.
  - Default FIFO_DEPTH and SOLVE_BUDGET constants. parser, solver and top_level share these.
- One sub-module: occupancy_counter. It is an up/down saturating counter with inc/dec inputs and a count output, and is reused for the peak tracker under the stats macro.

Test Plan:
- Basic board: 5 parse_write beats then parsed → occupancy 5. solve_start pulses once, on the cycle after parsed; phase=1.
- SOLVE traffic:
  - solve_next with solve_write in the same cycle ×3 → occupancy stays 5, fifo_rd_en=fifo_wr_en=1 each cycle.
  - solve_next with fifo_empty=1 → fifo_rd_en=0.
- Drain: solved → TRANSMIT with assemble_start pulse; assembled with 2 entries left → FLUSH holds rd_en high 2 cycles, then phase=0 and occupancy 0.
- Wrong-phase write: solve_write during RECEIVE → fifo_wr_en=0, bad_write=1 and sticky until rst.
- Overflow: with SOLVE_BUDGET=100, fill to FIFO_DEPTH and then write again → no wr_en, overflow=1. Without solved, ERROR on the 100th SOLVE cycle → error=1; parsed → FLUSH → RECEIVE.
- Reset mid-SOLVE: assert rst in SOLVE with occupancy 7 → the next cycle shows phase=0, occupancy=0, all flags 0.

Source files
------------

// File: rtl/nono_pkg.sv
// Shared types and constants for the board pipeline: phase encoding, line width and the
// default FIFO depth / solve budget used by parser, solver and top_level.
package nono_pkg;

  localparam int unsigned LINE_W               = 16;
  localparam int unsigned DEFAULT_FIFO_DEPTH   = 1024;
  localparam int unsigned DEFAULT_SOLVE_BUDGET = 50_000_000;

  typedef enum logic [2:0] {
    PhReceive  = 3'd0,
    PhSolve    = 3'd1,
    PhTransmit = 3'd2,
    PhFlush    = 3'd3,
    PhError    = 3'd4
  } phase_t;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/line_fifo_sequencer_if.sv
// Bundle between the line FIFO sequencer and its clients (parser, solver, assembler, FIFO IP).
// With LINE_FIFO_SEQ_STATS_EN defined it also carries solve_cycles and peak_occupancy.
interface line_fifo_sequencer_if #(
  parameter int unsigned FIFO_DEPTH = nono_pkg::DEFAULT_FIFO_DEPTH
);
  import nono_pkg::*;

  localparam int unsigned OCC_W = occ_width(FIFO_DEPTH);

  logic              parse_write;
  logic [LINE_W-1:0] parse_line;
  logic              parsed;
  logic              solve_write;
  logic [LINE_W-1:0] solve_line;
  logic              solve_next;
  logic              solved;
  logic              assembled;
  logic              fifo_full;
  logic              fifo_empty;

  logic [LINE_W-1:0] fifo_din;
  logic              fifo_wr_en;
  logic              fifo_rd_en;
  logic [2:0]        phase;
  logic              solve_start;
  logic              assemble_start;
  logic [OCC_W-1:0]  occupancy;
  logic              overflow;
  logic              bad_write;
  logic              error;
`ifdef LINE_FIFO_SEQ_STATS_EN
  logic [31:0]       solve_cycles;
  logic [OCC_W-1:0]  peak_occupancy;
`endif

  modport master (
    output parse_write, parse_line, parsed, solve_write, solve_line, solve_next,
    output solved, assembled, fifo_full, fifo_empty,
    input  fifo_din, fifo_wr_en, fifo_rd_en, phase, solve_start, assemble_start,
    input  occupancy, overflow, bad_write, error
`ifdef LINE_FIFO_SEQ_STATS_EN
    , input solve_cycles, peak_occupancy
`endif
  );

  modport slave (
    input  parse_write, parse_line, parsed, solve_write, solve_line, solve_next,
    input  solved, assembled, fifo_full, fifo_empty,
    output fifo_din, fifo_wr_en, fifo_rd_en, phase, solve_start, assemble_start,
    output occupancy, overflow, bad_write, error
`ifdef LINE_FIFO_SEQ_STATS_EN
    , output solve_cycles, peak_occupancy
`endif
  );

endinterface

// File: rtl/line_fifo_sequencer_occupancy_counter.sv
// Up/down counter saturating at 0 and MAX_COUNT; simultaneous inc and dec cancel.
module occupancy_counter #(
  parameter int unsigned MAX_COUNT = 1024,
  localparam int unsigned CntW     = $clog2(MAX_COUNT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] count_o
);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i && (count_q != CntW'(MAX_COUNT))) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/line_fifo_sequencer.sv
// Board phase machine (RECEIVE/SOLVE/TRANSMIT/FLUSH/ERROR) owning the shared line FIFO write mux,
// read gating and occupancy. Optional stats outputs are built when LINE_FIFO_SEQ_STATS_EN is set.
module line_fifo_sequencer #(
  parameter int unsigned FIFO_DEPTH   = nono_pkg::DEFAULT_FIFO_DEPTH,
  parameter int unsigned SOLVE_BUDGET = nono_pkg::DEFAULT_SOLVE_BUDGET
) (
  input logic                  clk,
  input logic                  rst,
  line_fifo_sequencer_if.slave bus
);
  import nono_pkg::*;

  localparam int unsigned OccW = occ_width(FIFO_DEPTH);

  phase_t            phase_q;
  logic [31:0]       wd_q;
  logic              solve_start_q;
  logic              assemble_start_q;
  logic              overflow_q;
  logic              bad_write_q;

  logic              wr_req;
  logic              wr_en;
  logic              rd_en;
  logic [LINE_W-1:0] din_mux;
  logic              bad_req;
  logic              wd_expired;
  logic [OccW-1:0]   occ;

  always_comb begin
    wr_req  = 1'b0;
    rd_en   = 1'b0;
    din_mux = '0;
    case (phase_q)
      PhReceive: begin
        din_mux = bus.parse_line;
        wr_req  = bus.parse_write;
      end
      PhSolve: begin
        din_mux = bus.solve_line;
        wr_req  = bus.solve_write;
        rd_en   = bus.solve_next & ~bus.fifo_empty;
      end
      PhFlush: rd_en = ~bus.fifo_empty;
      default: ;
    endcase
  end

  assign wr_en      = wr_req & ~bus.fifo_full;
  assign bad_req    = (bus.parse_write & (phase_q != PhReceive)) |
                      (bus.solve_write & (phase_q != PhSolve));
  assign wd_expired = (wd_q == 32'(SOLVE_BUDGET - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q          <= PhReceive;
      wd_q             <= '0;
      solve_start_q    <= 1'b0;
      assemble_start_q <= 1'b0;
      overflow_q       <= 1'b0;
      bad_write_q      <= 1'b0;
    end else begin
      solve_start_q    <= 1'b0;
      assemble_start_q <= 1'b0;
      if (wr_req && bus.fifo_full) overflow_q <= 1'b1;
      if (bad_req) bad_write_q <= 1'b1;
      case (phase_q)
        PhReceive: begin
          if (bus.parsed) begin
            phase_q       <= PhSolve;
            wd_q          <= '0;
            solve_start_q <= 1'b1;
          end
        end
        PhSolve: begin
          wd_q <= wd_q + 32'd1;
          // A solve finishing on the budget's last cycle still counts as solved.
          if (bus.solved) begin
            phase_q          <= PhTransmit;
            assemble_start_q <= 1'b1;
          end else if (wd_expired) begin
            phase_q <= PhError;
          end
        end
        PhTransmit: if (bus.assembled) phase_q <= PhFlush;
        PhFlush:    if (bus.fifo_empty) phase_q <= PhReceive;
        PhError:    if (bus.parsed) phase_q <= PhFlush;
        default:    phase_q <= PhError;
      endcase
    end
  end

  occupancy_counter #(
    .MAX_COUNT(FIFO_DEPTH)
  ) u_occ (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (1'b0),
    .inc_i  (wr_en),
    .dec_i  (rd_en),
    .count_o(occ)
  );

  assign bus.fifo_din       = din_mux;
  assign bus.fifo_wr_en     = wr_en;
  assign bus.fifo_rd_en     = rd_en;
  assign bus.phase          = phase_q;
  assign bus.solve_start    = solve_start_q;
  assign bus.assemble_start = assemble_start_q;
  assign bus.occupancy      = occ;
  assign bus.overflow       = overflow_q;
  assign bus.bad_write      = bad_write_q;
  assign bus.error          = (phase_q == PhError);

`ifdef LINE_FIFO_SEQ_STATS_EN
  logic [31:0]     solve_cycles_q;
  logic [OccW-1:0] peak;
  logic            occ_up;
  logic            peak_inc;
  logic            receive_entry;

  assign occ_up        = wr_en & ~rd_en & (occ != OccW'(FIFO_DEPTH));
  // Occupancy moves by at most one per cycle, so the peak can track it by single steps.
  assign peak_inc      = (occ > peak) | (occ_up & (occ == peak));
  assign receive_entry = (phase_q == PhFlush) & bus.fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      solve_cycles_q <= '0;
    end else if ((phase_q == PhSolve) && (bus.solved || wd_expired)) begin
      solve_cycles_q <= wd_q;
    end
  end

  occupancy_counter #(
    .MAX_COUNT(FIFO_DEPTH)
  ) u_peak (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (receive_entry),
    .inc_i  (peak_inc),
    .dec_i  (1'b0),
    .count_o(peak)
  );

  assign bus.solve_cycles   = solve_cycles_q;
  assign bus.peak_occupancy = peak;
`endif

endmodule

// File: tb/tb_line_fifo_sequencer.sv
// Directed plus randomized bench for line_fifo_sequencer against a queue-based FIFO and a
// phase-level reference model.
module tb_line_fifo_sequencer;
  import nono_pkg::*;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned BUDGET = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_fifo_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();

  line_fifo_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .SOLVE_BUDGET(BUDGET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: phase number, cycles spent in the current SOLVE visit, flags.
  int                m_phase;
  int                m_occ;
  int                m_age;
  bit                m_ovf;
  bit                m_bad;
  bit                m_ss;
  bit                m_as;
  logic [LINE_W-1:0] fifo_q[$];
  bit                empty_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_occ = 0; m_age = 0;
    m_ovf = 1'b0; m_bad = 1'b0; m_ss = 1'b0; m_as = 1'b0;
  endtask

  task automatic drive_flags();
    bus.fifo_full  = (fifo_q.size() >= DEPTH);
    bus.fifo_empty = (fifo_q.size() == 0) || empty_ovr;
  endtask

  task automatic idle();
    bus.parse_write = 1'b0; bus.parse_line = '0; bus.parsed = 1'b0;
    bus.solve_write = 1'b0; bus.solve_line = '0; bus.solve_next = 1'b0;
    bus.solved = 1'b0; bus.assembled = 1'b0;
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    fifo_q.delete();
    drive_flags();
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_flags();
  endtask

  // One clock: check every output against the model, then advance model and FIFO.
  task automatic step();
    bit                wreq, wr, rd;
    logic [LINE_W-1:0] din;
    drive_flags();
    #1;
    wreq = (m_phase == 0 && bus.parse_write) || (m_phase == 1 && bus.solve_write);
    wr   = wreq && !bus.fifo_full;
    rd   = ((m_phase == 1 && bus.solve_next) || m_phase == 3) && !bus.fifo_empty;
    din  = (m_phase == 0) ? bus.parse_line : (m_phase == 1) ? bus.solve_line : '0;
    check("wr_en", bus.fifo_wr_en, wr);
    check("rd_en", bus.fifo_rd_en, rd);
    check("din", bus.fifo_din, din);
    check("phase", bus.phase, m_phase);
    check("occupancy", bus.occupancy, m_occ);
    check("overflow", bus.overflow, m_ovf);
    check("bad_write", bus.bad_write, m_bad);
    check("error", bus.error, (m_phase == 4));
    check("solve_start", bus.solve_start, m_ss);
    check("assemble_start", bus.assemble_start, m_as);
    @(posedge clk);
    if (rst) begin
      model_reset();
      fifo_q.delete();
    end else begin
      if (rd) void'(fifo_q.pop_front());
      if (wr) fifo_q.push_back(din);
      if (wr && !rd && m_occ < DEPTH) m_occ++;
      else if (rd && !wr && m_occ > 0) m_occ--;
      m_ovf = m_ovf | (wreq && bus.fifo_full);
      m_bad = m_bad | (bus.parse_write && m_phase != 0) || (bus.solve_write && m_phase != 1);
      m_ss = 1'b0;
      m_as = 1'b0;
      case (m_phase)
        0: if (bus.parsed) begin m_phase = 1; m_ss = 1'b1; m_age = 0; end
        1: begin
          m_age++;
          if (bus.solved) begin m_phase = 2; m_as = 1'b1; end
          else if (m_age == BUDGET) m_phase = 4;
        end
        2: if (bus.assembled) m_phase = 3;
        3: if (bus.fifo_empty) m_phase = 0;
        4: if (bus.parsed) m_phase = 3;
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    idle();
    hard_reset();
    check("rst_phase", bus.phase, 0);
    check("rst_occ", bus.occupancy, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_bad", bus.bad_write, 0);
    check("rst_ss", bus.solve_start, 0);
    check("rst_as", bus.assemble_start, 0);
    check("rst_error", bus.error, 0);

    // Basic board: five lines then parsed.
    for (int i = 0; i < 5; i++) begin
      bus.parse_write = 1'b1; bus.parse_line = LINE_W'($urandom); step();
    end
    bus.parse_write = 1'b0; bus.parsed = 1'b1; step(); bus.parsed = 1'b0;
    check("board_occ", bus.occupancy, 5);
    check("board_ss", bus.solve_start, 1);
    check("board_phase", bus.phase, 1);
    step();
    check("ss_single", bus.solve_start, 0);

    // Simultaneous pop and write-back leave occupancy unchanged.
    bus.solve_next = 1'b1; bus.solve_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.solve_line = LINE_W'($urandom);
      drive_flags(); #1;
      check("traffic_rd", bus.fifo_rd_en, 1);
      check("traffic_wr", bus.fifo_wr_en, 1);
      step();
    end
    check("traffic_occ", bus.occupancy, 5);
    bus.solve_write = 1'b0;
    empty_ovr = 1'b1; drive_flags(); #1;
    check("rd_gate_empty", bus.fifo_rd_en, 0);
    step(); empty_ovr = 1'b0;
    for (int i = 0; i < 3; i++) step();
    bus.solve_next = 1'b0;
    check("pop_occ", bus.occupancy, 2);

    // Solve, transmit, flush two entries.
    bus.solved = 1'b1; step(); bus.solved = 1'b0;
    check("tx_phase", bus.phase, 2);
    check("tx_as", bus.assemble_start, 1);
    bus.assembled = 1'b1; step(); bus.assembled = 1'b0;
    check("flush_phase", bus.phase, 3);
    drive_flags(); #1; check("flush_rd0", bus.fifo_rd_en, 1);
    step();
    drive_flags(); #1; check("flush_rd1", bus.fifo_rd_en, 1);
    step(); step();
    check("flush_done_phase", bus.phase, 0);
    check("flush_done_occ", bus.occupancy, 0);

    // Wrong-phase write is dropped and sticky.
    bus.solve_write = 1'b1; drive_flags(); #1;
    check("wrong_wr_en", bus.fifo_wr_en, 0);
    step(); bus.solve_write = 1'b0;
    check("bad_set", bus.bad_write, 1);
    repeat (3) step();
    check("bad_sticky", bus.bad_write, 1);

    // Fill to depth, then overflow.
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus.parse_write = 1'b1; bus.parse_line = LINE_W'($urandom); step();
    end
    check("fill_occ", bus.occupancy, DEPTH);
    drive_flags(); #1;
    check("full_wr_en", bus.fifo_wr_en, 0);
    step(); bus.parse_write = 1'b0;
    check("overflow_set", bus.overflow, 1);
    check("full_occ", bus.occupancy, DEPTH);

    // Watchdog expiry, then recovery through FLUSH with refused parse writes.
    bus.parsed = 1'b1; step(); bus.parsed = 1'b0;
    for (int i = 0; i < int'(BUDGET) - 1; i++) step();
    check("wd_last_cycle", bus.phase, 1);
    step();
    check("wd_error", bus.error, 1);
    check("wd_phase", bus.phase, 4);
    bus.parsed = 1'b1; step(); bus.parsed = 1'b0;
    check("recover_phase", bus.phase, 3);
    bus.parse_write = 1'b1;
    n = 0;
    while (bus.phase != 3'd0 && n < 20) begin
      bus.parse_line = LINE_W'($urandom); step(); n++;
    end
    bus.parse_write = 1'b0;
    check("recover_bound", (n < 20), 1);
    check("recover_occ", bus.occupancy, 0);

    // Reset mid-SOLVE with occupancy 7 and a flag set.
    hard_reset();
    for (int i = 0; i < 7; i++) begin
      bus.parse_write = 1'b1; bus.parse_line = LINE_W'($urandom); step();
    end
    bus.parse_write = 1'b0; bus.parsed = 1'b1; step(); bus.parsed = 1'b0;
    bus.parse_write = 1'b1; step(); bus.parse_write = 1'b0;
    check("pre_rst_occ", bus.occupancy, 7);
    check("pre_rst_bad", bus.bad_write, 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_phase", bus.phase, 0);
    check("mid_rst_occ", bus.occupancy, 0);
    check("mid_rst_bad", bus.bad_write, 0);
    check("mid_rst_ovf", bus.overflow, 0);
    check("mid_rst_ss", bus.solve_start, 0);
    check("mid_rst_err", bus.error, 0);

    // Random soak against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.parse_write = 1'($urandom_range(0, 1));
      bus.parse_line  = LINE_W'($urandom);
      bus.parsed      = ($urandom_range(0, 11) == 0);
      bus.solve_write = ($urandom_range(0, 2) == 0);
      bus.solve_line  = LINE_W'($urandom);
      bus.solve_next  = 1'($urandom_range(0, 1));
      bus.solved      = ($urandom_range(0, 59) == 0);
      bus.assembled   = ($urandom_range(0, 7) == 0);
      empty_ovr       = ($urandom_range(0, 15) == 0);
      rst             = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; empty_ovr = 1'b0; idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
